if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch initiator for the 5-stage MIPS pipeline.
- Owns the PC register and drives the fetch address to the combinational instruction ROM.
- Captures the returned word into the IF/ID pipeline register.
- Applies the stall, branch/jump redirect and flush requests that come from the hazard unit and the decode stage.

Parameters:
PC_RESET, 32'h00003000, PC value loaded on reset
IM_BASE, 32'h00003000, byte address of ROM word 0
IM_WORDS, 4096, ROM depth in 32-bit words (legal range IM_BASE .. IM_BASE+4*IM_WORDS-4)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hazard unit: hold PC and IF/ID this cycle
redirect_valid  input  1  decode stage: branch taken / jump resolved
redirect_pc  input  32  target address for redirect
flush_d  input  1  clear IF/ID to a bubble (exception / eret)
im_addr  output  32  fetch address to ROM (combinational = PC)
im_instr  input  32  ROM read data, combinational from im_addr
instr_d  output  32  IF/ID instruction
pc_d  output  32  IF/ID PC of instr_d
pc8_d  output  32  IF/ID PC+8 (link address)
valid_d  output  1  IF/ID holds a real fetched instruction
exc_d  output  1  IF/ID fetch-address exception flag (see Optional Feature)

Behaviour:
- Reset (sync, clk edge with reset=1): PC<=PC_RESET; instr_d<=0; pc_d<=PC_RESET; pc8_d<=PC_RESET+8; valid_d<=0; exc_d<=0.
- im_addr = PC at all times, with no register stage. ROM data is sampled at the same edge, so fetch latency is 1 cycle: a word fetched in cycle n is visible on instr_d in cycle n+1.
- PC next-state priority, highest first:
  - reset
  - stall=1: PC holds
  - redirect_valid=1: PC<=redirect_pc
  - otherwise: PC<=PC+4
- redirect_valid while stall=1 is ignored. The decoder must not rely on it being honoured; it re-asserts after the stall.
- MIPS delay slot:
  - The word in IF when the redirect is applied is the delay slot.
  - It is captured into IF/ID normally and is never squashed by redirect.
- IF/ID next-state priority, highest first:
  - reset
  - flush_d=1: bubble, i.e. instr_d<=0 (sll $0 NOP), valid_d<=0, exc_d<=0, pc_d/pc8_d<=current PC/PC+8. Flush overrides stall.
  - stall=1: hold all IF/ID fields
  - otherwise: instr_d<=im_instr, pc_d<=PC, pc8_d<=PC+8, valid_d<=1, exc_d per Optional Feature
- flush_d does not affect PC; PC follows its own priority list.
- Arithmetic:
  - PC+4 and PC+8 are 32-bit modulo 2^32, so 32'hFFFFFFFC+4 wraps to 0 with no flag.
  - redirect_pc is taken verbatim; low bits are not masked.
- Simultaneous stall+flush_d: PC holds, IF/ID becomes a bubble.
- Reset mid-stall or mid-redirect: reset wins and all pending requests are dropped.

Optional Feature:
Macro IF_ADDR_CHECK_EN.
- Defined: a fetch is bad if PC[1:0]!=0 or PC<IM_BASE or PC>IM_BASE+4*IM_WORDS-4.
  - On capture of a bad fetch: instr_d<=0, exc_d<=1, valid_d<=1.
  - pc_d still holds the offending PC, so EPC can be taken from it.
  - PC continues sequentially; the exception unit is expected to redirect and flush.
- Not defined: no check; exc_d is constant 0 and im_instr is captured unconditionally.

Test Plan:
1. Reset 2 cycles, release -> im_addr=0x3000; after 1st edge instr_d=ROM[0], pc_d=0x3000, pc8_d=0x3008, valid_d=1; im_addr=0x3004.
2. Sequential run 4 cycles -> pc_d=0x3000, 0x3004, 0x3008, 0x300C on consecutive cycles; no gaps.
3. stall=1 for 3 cycles at PC=0x3010 -> im_addr stays 0x3010; instr_d/pc_d frozen at 0x300C contents; on release pc_d=0x3010 next edge.
4. redirect_valid=1 with redirect_pc=0x3100 while PC=0x3008 -> delay slot 0x3008 captured (pc_d=0x3008); next cycle im_addr=0x3100; following pc_d=0x3100. Same request asserted during stall=1 -> PC unchanged.
5. flush_d=1 together with stall=1 at PC=0x3020 -> instr_d=0, valid_d=0; PC holds 0x3020; next free edge pc_d=0x3020.
6. With IF_ADDR_CHECK_EN, redirect_pc=0x3002 and separately 0x7000 -> captured instr_d=0, exc_d=1, pc_d=0x3002/0x7000. Without the macro -> exc_d=0, instr_d=im_instr.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, fetch address to the combinational ROM, IF/ID register.
// Optional fetch-address check enabled by defining IF_ADDR_CHECK_EN.
module if_stage #(
   parameter logic [31:0] PC_RESET = 32'h0000_3000,
   parameter logic [31:0] IM_BASE  = 32'h0000_3000,
   parameter int          IM_WORDS = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        flush_d,
   output logic [31:0] im_addr,
   input  logic [31:0] im_instr,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc8_d,
   output logic        valid_d,
   output logic        exc_d
);

   localparam logic [31:0] IM_LAST = IM_BASE + 32'(4 * IM_WORDS) - 32'd4;
`ifdef IF_ADDR_CHECK_EN
   localparam logic CHECK_EN = 1'b1;
`else
   localparam logic CHECK_EN = 1'b0;
`endif

   logic [31:0] pc_q, pc_nxt_d;
   logic [31:0] ifid_instr_q, ifid_instr_d;
   logic [31:0] ifid_pc_q, ifid_pc_d;
   logic [31:0] ifid_pc8_q, ifid_pc8_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic        ifid_exc_q, ifid_exc_d;
   logic        bad_fetch;

   assign im_addr = pc_q;

   // Misaligned or outside the ROM window; folds to 0 when the check is disabled.
   assign bad_fetch = CHECK_EN &&
                      ((pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q > IM_LAST));

   always_comb begin
      pc_nxt_d = pc_q + 32'd4;
      if (stall) begin
         pc_nxt_d = pc_q;
      end else if (redirect_valid) begin
         pc_nxt_d = redirect_pc;
      end
   end

   always_comb begin
      ifid_instr_d = ifid_instr_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_pc8_d   = ifid_pc8_q;
      ifid_valid_d = ifid_valid_q;
      ifid_exc_d   = ifid_exc_q;
      if (flush_d) begin
         ifid_instr_d = 32'd0;
         ifid_pc_d    = pc_q;
         ifid_pc8_d   = pc_q + 32'd8;
         ifid_valid_d = 1'b0;
         ifid_exc_d   = 1'b0;
      end else if (!stall) begin
         // The delay-slot word is captured like any other; redirect never squashes it.
         ifid_instr_d = bad_fetch ? 32'd0 : im_instr;
         ifid_pc_d    = pc_q;
         ifid_pc8_d   = pc_q + 32'd8;
         ifid_valid_d = 1'b1;
         ifid_exc_d   = bad_fetch;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q         <= PC_RESET;
         ifid_instr_q <= 32'd0;
         ifid_pc_q    <= PC_RESET;
         ifid_pc8_q   <= PC_RESET + 32'd8;
         ifid_valid_q <= 1'b0;
         ifid_exc_q   <= 1'b0;
      end else begin
         pc_q         <= pc_nxt_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_pc8_q   <= ifid_pc8_d;
         ifid_valid_q <= ifid_valid_d;
         ifid_exc_q   <= ifid_exc_d;
      end
   end

   assign instr_d = ifid_instr_q;
   assign pc_d    = ifid_pc_q;
   assign pc8_d   = ifid_pc8_q;
   assign valid_d = ifid_valid_q;
   assign exc_d   = ifid_exc_q;

endmodule
